// File: rtl/drawbridge_pkg.sv
// Shared types and helpers for the drawbridge controller.
// The DRAWBRIDGE_TIMEOUT_EN macro (see drawbridge_ctrl.sv) adds the motor timeout fault.
package drawbridge_pkg;

    typedef enum logic [2:0] {
        DOWN     = 3'd0,
        WARN     = 3'd1,
        RAISING  = 3'd2,
        UPRIGHT  = 3'd3,
        LOWERING = 3'd4,
        FAULT    = 3'd5
    } state_t;

    // Width needed to count up to the largest of the three timing limits.
    function automatic int timer_width(input int warn_c, input int hold_c, input int motor_c);
        int m;
        m = warn_c;
        if (hold_c > m) m = hold_c;
        if (motor_c > m) m = motor_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/drawbridge_timer.sv
// Shared state timer: clearable, loadable, freezable, saturating up-counter
// whose done flag is set once the count has reached the supplied limit.
module drawbridge_timer #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             freeze,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!freeze && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count >= limit);

endmodule

// File: rtl/drawbridge_ctrl.sv
// Drawbridge controller: one registered FSM for the raise/hold/lower cycle.
// Define DRAWBRIDGE_TIMEOUT_EN to fault when RAISING/LOWERING runs past MOTOR_TIMEOUT.
module drawbridge_ctrl
    import drawbridge_pkg::*;
#(
    parameter int N_LANES       = 2,
    parameter int WARN_CYCLES   = 16,
    parameter int HOLD_CYCLES   = 64,
    parameter int MOTOR_TIMEOUT = 1024
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               BoatReq,
    input  logic               BoatClear,
    input  logic               LimUp,
    input  logic               LimDown,
    input  logic [N_LANES-1:0] Deck,
    input  logic               Obstacle,
    output logic               MT,
    output logic               MDir,
    output logic               AL,
    output logic               TFL,
    output logic               BFL,
    output logic               Fault,
    output logic [2:0]         State
);

    localparam int TW = timer_width(WARN_CYCLES, HOLD_CYCLES, MOTOR_TIMEOUT);
    localparam logic [TW-1:0] LIM_WARN  = TW'(WARN_CYCLES - 1);
    localparam logic [TW-1:0] LIM_HOLD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] LIM_MOTOR = TW'(MOTOR_TIMEOUT - 1);

    state_t          state, next_state;
    logic            timer_clear, timer_freeze, timer_done, timed_out;
    logic [TW-1:0]   timer_limit;
    logic            mt_d, mdir_d, al_d, tfl_d, bfl_d, fault_d;

    drawbridge_timer #(.WIDTH(TW)) u_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .clear      (timer_clear),
        .load       (1'b0),
        .load_value ('0),
        .freeze     (timer_freeze),
        .limit      (timer_limit),
        .done       (timer_done)
    );

`ifdef DRAWBRIDGE_TIMEOUT_EN
    assign timed_out = timer_done;
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        timer_limit  = LIM_MOTOR;
        timer_freeze = 1'b0;

        if (LimUp && LimDown) begin
            next_state = FAULT;
        end else begin
            case (state)
                DOWN: begin
                    if (BoatReq)       next_state = WARN;
                    else if (!LimDown) next_state = LOWERING;
                end
                WARN: begin
                    timer_limit = LIM_WARN;
                    if (Deck == '0 && timer_done && !Obstacle) next_state = RAISING;
                end
                RAISING: begin
                    timer_freeze = Obstacle;
                    if (timed_out)     next_state = FAULT;
                    else if (Obstacle) next_state = RAISING;
                    else if (LimUp)    next_state = UPRIGHT;
                end
                UPRIGHT: begin
                    timer_limit = LIM_HOLD;
                    if (timer_done && BoatClear && !BoatReq) next_state = LOWERING;
                end
                LOWERING: begin
                    timer_freeze = Obstacle;
                    if (timed_out)     next_state = FAULT;
                    else if (Obstacle) next_state = LOWERING;
                    else if (LimDown)  next_state = DOWN;
                end
                FAULT:   next_state = FAULT;
                default: next_state = FAULT;
            endcase
        end

        // Deck traffic restarts the warning, a new boat request restarts the hold.
        timer_clear = (next_state != state)
                    || (state == WARN && Deck != '0)
                    || (state == UPRIGHT && BoatReq);
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        mt_d    = 1'b0;
        mdir_d  = 1'b0;
        al_d    = 1'b0;
        tfl_d   = 1'b0;
        bfl_d   = 1'b0;
        fault_d = 1'b0;
        case (next_state)
            WARN: begin
                al_d  = 1'b1;
                tfl_d = 1'b1;
            end
            RAISING: begin
                mt_d   = !Obstacle;
                mdir_d = 1'b1;
                al_d   = 1'b1;
                tfl_d  = 1'b1;
            end
            UPRIGHT: begin
                tfl_d = 1'b1;
                bfl_d = 1'b1;
            end
            LOWERING: begin
                mt_d  = !Obstacle;
                al_d  = 1'b1;
                tfl_d = 1'b1;
            end
            FAULT: begin
                al_d    = 1'b1;
                tfl_d   = 1'b1;
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= DOWN;
            MT    <= 1'b0;
            MDir  <= 1'b0;
            AL    <= 1'b0;
            TFL   <= 1'b0;
            BFL   <= 1'b0;
            Fault <= 1'b0;
        end else begin
            state <= next_state;
            MT    <= mt_d;
            MDir  <= mdir_d;
            AL    <= al_d;
            TFL   <= tfl_d;
            BFL   <= bfl_d;
            Fault <= fault_d;
        end
    end

    assign State = state;

endmodule

// File: tb/tb_drawbridge_ctrl.sv
// Self-checking bench for drawbridge_ctrl using an expected-output queue.
// Expectations follow DRAWBRIDGE_TIMEOUT_EN when it is defined for the build.
module tb_drawbridge_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       BoatReq, BoatClear, LimUp, LimDown, Obstacle;
    logic [1:0] Deck;
    logic       MT, MDir, AL, TFL, BFL, Fault;
    logic [2:0] State;

    int compared   = 0;
    int mismatched = 0;

    logic [8:0] expQ[$];
    string      tagQ[$];

    // {State, MT, MDir, AL, TFL, BFL, Fault}
    localparam logic [8:0] E_DOWN   = {3'd0, 6'b000000};
    localparam logic [8:0] E_WARN   = {3'd1, 6'b001100};
    localparam logic [8:0] E_RAISE  = {3'd2, 6'b111100};
    localparam logic [8:0] E_RPAUSE = {3'd2, 6'b011100};
    localparam logic [8:0] E_UP     = {3'd3, 6'b000110};
    localparam logic [8:0] E_LOWER  = {3'd4, 6'b101100};
    localparam logic [8:0] E_LPAUSE = {3'd4, 6'b001100};
    localparam logic [8:0] E_FAULT  = {3'd5, 6'b001101};

    drawbridge_ctrl #(
        .N_LANES(2), .WARN_CYCLES(16), .HOLD_CYCLES(64), .MOTOR_TIMEOUT(1024)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .BoatReq   (BoatReq),
        .BoatClear (BoatClear),
        .LimUp     (LimUp),
        .LimDown   (LimDown),
        .Deck      (Deck),
        .Obstacle  (Obstacle),
        .MT        (MT),
        .MDir      (MDir),
        .AL        (AL),
        .TFL       (TFL),
        .BFL       (BFL),
        .Fault     (Fault),
        .State     (State)
    );

    always #5 Clock = ~Clock;

    function automatic logic [8:0] observed();
        return {State, MT, MDir, AL, TFL, BFL, Fault};
    endfunction

    task automatic checkOutput(input string tag, input logic [8:0] got, input logic [8:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     tag, got[8:6], got[5:0], want[8:6], want[5:0]);
        end
    endtask

    // Push the expectation for the coming edge, clock once, then pop and compare.
    task automatic applyStimulus(input string tag, input logic [8:0] want);
        logic [8:0] e;
        string      t;
        expQ.push_back(want);
        tagQ.push_back(tag);
        @(posedge Clock);
        #1;
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput(t, observed(), e);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b0; BoatReq = 1'b0; BoatClear = 1'b0;
        LimUp = 1'b0; LimDown = 1'b1; Obstacle = 1'b0; Deck = 2'b00;
        #12;
        checkOutput("reset", observed(), E_DOWN);
        Reset = 1'b1;
        applyStimulus("idleDown", E_DOWN);

        // Raise: exactly 16 WARN cycles, then the motor starts upward.
        BoatReq = 1'b1;
        applyStimulus("enterWarn", E_WARN);
        BoatReq = 1'b0;
        for (int i = 1; i < 16; i++) applyStimulus("warnHold", E_WARN);
        applyStimulus("raiseStart", E_RAISE);
        LimDown = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("raising", E_RAISE);

        Obstacle = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus("raisePause", E_RPAUSE);
        Obstacle = 1'b0;
        applyStimulus("raiseResume", E_RAISE);

        LimUp = 1'b1;
        applyStimulus("upright", E_UP);
        for (int i = 2; i <= 64; i++) begin
            if (i >= 5) BoatClear = 1'b1;
            applyStimulus("uprightHold", E_UP);
        end
        applyStimulus("lowerStart", E_LOWER);
        LimUp = 1'b0; BoatClear = 1'b0;
        applyStimulus("lowering", E_LOWER);
        Obstacle = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus("lowerPause", E_LPAUSE);
        Obstacle = 1'b0;
        applyStimulus("lowerResume", E_LOWER);
        LimDown = 1'b1;
        applyStimulus("backDown", E_DOWN);

        // Deck traffic restarts the warning timer.
        BoatReq = 1'b1;
        applyStimulus("warnAgain", E_WARN);
        BoatReq = 1'b0;
        Deck = 2'b01;
        for (int i = 0; i < 10; i++) applyStimulus("deckBusy", E_WARN);
        Deck = 2'b00;
        for (int i = 1; i < 16; i++) applyStimulus("deckClear", E_WARN);
        applyStimulus("raiseAfterDeck", E_RAISE);
        LimDown = 1'b0;

`ifdef DRAWBRIDGE_TIMEOUT_EN
        for (int i = 1; i < 1024; i++) applyStimulus("raiseToTimeout", E_RAISE);
        applyStimulus("timeoutFault", E_FAULT);
        LimDown = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("faultHeld", E_FAULT);
`else
        for (int i = 0; i < 1100; i++) applyStimulus("raiseNoTimeout", E_RAISE);
`endif

        // Asynchronous reset mid-motion clears outputs without a clock edge.
        Reset = 1'b0;
        #1;
        checkOutput("resetMidMotion", observed(), E_DOWN);
        LimDown = 1'b1;
        #1;
        Reset = 1'b1;
        applyStimulus("downAfterReset", E_DOWN);

        // Both limit switches together force FAULT, held until reset.
        LimUp = 1'b1;
        applyStimulus("conflictFault", E_FAULT);
        LimUp = 1'b0; BoatReq = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("conflictHeld", E_FAULT);
        BoatReq = 1'b0;
        Reset = 1'b0;
        #1;
        checkOutput("resetFromFault", observed(), E_DOWN);
        LimDown = 1'b0;
        #1;
        Reset = 1'b1;
        applyStimulus("recoverLowering", E_LOWER);
        LimDown = 1'b1;
        applyStimulus("recoverDown", E_DOWN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/drawbridge_ctrl.md
# drawbridge_ctrl

Complete drawbridge controller for the ponte-levadiça design. A single registered FSM covers the whole raise/hold/lower cycle, replacing the per-state decoding of the earlier upright block. It is parametrised in deck lane count, warning time, minimum upright hold time and motor timeout. It drives the motor, alarm, road light and boat light from limit switches, boat request/clear, per-lane deck presence and obstacle sensors.

## Interface
- N_LANES, 2, number of deck vehicle-presence sensors (≥1)
- WARN_CYCLES, 16, alarm/road-red time before the motor starts (≥1)
- HOLD_CYCLES, 64, minimum cycles held in UPRIGHT (≥1)
- MOTOR_TIMEOUT, 1024, maximum cycles in RAISING/LOWERING (≥2)
- Clock  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- BoatReq  in  1  boat waiting to pass
- BoatClear  in  1  boat has passed the span
- LimUp  in  1  span fully raised
- LimDown  in  1  span fully lowered
- Deck  in  N_LANES  vehicle present on lane i
- Obstacle  in  1  obstruction under or on the moving span
- MT  out  1  motor run
- MDir  out  1  motor direction, 1 = raise, 0 = lower
- AL  out  1  alarm
- TFL  out  1  road light red (1) / green (0)
- BFL  out  1  boat light green (1) / red (0)
- Fault  out  1  latched fault
- State  out  3  current state encoding, for debug

## Operation
- Reset state is DOWN.
- Every output is a register. Every output resets to 0.
- DOWN (all outputs 0):
  - BoatReq → WARN.
  - Otherwise, if !LimDown → LOWERING. This is recovery after a reset taken mid-span.
- WARN (AL=1, TFL=1):
  - The timer counts WARN_CYCLES.
  - On expiry with Deck==0 and !Obstacle → RAISING.
  - Any Deck bit set restarts the timer and the state holds.
- RAISING (MT=1, MDir=1, AL=1, TFL=1):
  - LimUp → UPRIGHT.
  - While Obstacle is high, MT=0, the state holds and the timer freezes.
- UPRIGHT (TFL=1, BFL=1):
  - Leaves after at least HOLD_CYCLES.
  - After that, BoatClear=1 with BoatReq=0 → LOWERING.
  - A fresh BoatReq extends the hold.
- LOWERING (MT=1, MDir=0, AL=1, TFL=1, BFL=0):
  - LimDown → DOWN.
  - Obstacle pauses the motor, as in RAISING.
- FAULT (AL=1, TFL=1, Fault=1, MT=0, BFL=0):
  - Exit only by Reset.
- LimUp && LimDown together in any state → FAULT. This has priority over every other transition.
- Priority within a state: sensor conflict > timeout > Obstacle pause > normal transition.
- The timer clears on every state change.

## Timing
- Input-to-output latency: 1 cycle. Inputs sampled at edge k drive outputs after edge k.
- A limit switch seen at edge k stops MT at edge k. MT is 0 from the cycle after the limit is sampled.
- WARN lasts exactly WARN_CYCLES cycles when the deck is clear throughout.
- UPRIGHT lasts at least HOLD_CYCLES cycles.
- The timer is $clog2(max(WARN_CYCLES, HOLD_CYCLES, MOTOR_TIMEOUT)+1) bits wide and saturates; it does not wrap.
- Reset asserted mid-motion: outputs go to 0 immediately (asynchronous). After release the block recovers through DOWN → LOWERING when LimDown=0.

## Configuration
- DRAWBRIDGE_TIMEOUT_EN defined:
  - RAISING or LOWERING exceeding MOTOR_TIMEOUT cycles (frozen Obstacle cycles excluded) → FAULT.
- Not defined:
  - No timeout comparison exists.
  - Motion continues until the limit switch.
  - FAULT is reachable only by sensor conflict.

## Structure
- Package drawbridge_pkg holds:
  - the state encoding constants DOWN=0, WARN=1, RAISING=2, UPRIGHT=3, LOWERING=4, FAULT=5;
  - the timer-width function.
- Sub-module drawbridge_timer:
  - loadable, clearable, freezable, saturating up-counter with a terminal compare;
  - instantiated once and shared by all states.

## Test plan
- Reset with LimDown=1, pulse BoatReq, Deck=0 → WARN for exactly 16 cycles, then MT=1/MDir=1. Assert LimUp → UPRIGHT, MT=0, BFL=1.
- In WARN, Deck=2'b01 for 10 cycles, then clear → the WARN count restarts; RAISING begins 16 cycles after the deck clears.
- In UPRIGHT, BoatClear=1 at cycle 5 → stays until cycle 64, then LOWERING. Assert LimDown → DOWN, all outputs 0.
- In RAISING, Obstacle=1 for 20 cycles → MT=0 and state held. On release, MT=1 with the timer resumed, not reset.
- With DRAWBRIDGE_TIMEOUT_EN and no LimUp for 1024 cycles → FAULT, Fault=1, AL=1, MT=0, held until Reset. Without the macro, RAISING persists.
- LimUp=1 and LimDown=1 together while DOWN → FAULT on the next edge. A later Reset low → all outputs 0; after release with LimDown=0 → LOWERING.
